pred_wb_arbiter: RTL and testbench

//  Upstream feeder of the predicate register file. Collects predicate results

---
 rtl/pred_wb_arbiter.sv | 168 ++++++++++++++++
 tb/tb_pred_wb_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pred_wb_arbiter.sv
// Predicate write-back arbiter: merges two compare result streams through a small FIFO
// into the predicate register file write port and tracks pending predicates.
module pred_wb_arbiter #(
    parameter int unsigned NUM_PREGS  = 16,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 alloc_valid,
    input  logic [ADDR_W-1:0]    alloc_addr,
    input  logic                 s0_valid,
    output logic                 s0_ready,
    input  logic [ADDR_W-1:0]    s0_addr,
    input  logic                 s0_data,
    input  logic                 s1_valid,
    output logic                 s1_ready,
    input  logic [ADDR_W-1:0]    s1_addr,
    input  logic                 s1_data,
    output logic                 write_enable,
    output logic [ADDR_W-1:0]    write_addr,
    output logic                 data_in,
    output logic [NUM_PREGS-1:0] busy_vec,
    output logic [ADDR_W-1:0]    fifo_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              data;
    } entry_t;

    entry_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               rr_pri;

    entry_t             head;
    entry_t             e0;
    entry_t             e1;
    entry_t             hi_entry;
    entry_t             lo_entry;
    entry_t             first_entry;
    entry_t             second_entry;
    logic               empty;
    logic               pop;
    logic [CNT_W-1:0]   free;
    logic               push0;
    logic               push1;
    logic               hi_push;
    logic               lo_push;
    logic               first_push;
    logic               second_push;
    logic [CNT_W-1:0]   n_push;
    logic               rr_toggle;
    logic [NUM_PREGS-1:0] busy_nxt;

    assign head         = mem[rd_ptr];
    assign write_enable = pop;
    assign write_addr   = head.addr;
    assign data_in      = head.data;
    assign fifo_count   = ADDR_W'(count);

    // Drain, acceptance and push ordering
    always_comb begin
        empty        = (count == '0);
        pop          = !empty && !reset && !flush;
        free         = CNT_W'(FIFO_DEPTH) - count + CNT_W'(pop);
        s0_ready     = 1'b0;
        s1_ready     = 1'b0;
        e0.addr      = s0_addr;
        e0.data      = s0_data;
        e1.addr      = s1_addr;
        e1.data      = s1_data;
        hi_entry     = e0;
        lo_entry     = e1;
        hi_push      = 1'b0;
        lo_push      = 1'b0;
        first_entry  = e0;
        second_entry = e1;
        first_push   = 1'b0;
        second_push  = 1'b0;
        n_push       = '0;
        rr_toggle    = 1'b0;

        if (!reset && !flush) begin
            if (free >= CNT_W'(2)) begin
                s0_ready = 1'b1;
                s1_ready = 1'b1;
            end else if (free == CNT_W'(1)) begin
                s0_ready = !rr_pri;
                s1_ready = rr_pri;
                rr_toggle = s0_valid && s1_valid;
            end
        end

        push0 = s0_valid && s0_ready;
        push1 = s1_valid && s1_ready;

        // Priority source goes first so the other source's value lands last
        if (rr_pri) begin
            hi_entry = e1;
            lo_entry = e0;
            hi_push  = push1;
            lo_push  = push0;
        end else begin
            hi_entry = e0;
            lo_entry = e1;
            hi_push  = push0;
            lo_push  = push1;
        end

        first_push   = hi_push || lo_push;
        first_entry  = hi_push ? hi_entry : lo_entry;
        second_push  = hi_push && lo_push;
        second_entry = lo_entry;
        n_push       = CNT_W'(first_push) + CNT_W'(second_push);
    end

    // Scoreboard: a same-cycle allocation overrides the drain clear
    always_comb begin
        busy_nxt = busy_vec;
        if (pop) begin
            busy_nxt[write_addr] = 1'b0;
        end
        if (alloc_valid) begin
            busy_nxt[alloc_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            rr_pri   <= 1'b0;
            busy_vec <= '0;
        end else if (flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            busy_vec <= '0;
        end else begin
            rd_ptr   <= rd_ptr + PTR_W'(pop);
            wr_ptr   <= wr_ptr + PTR_W'(n_push);
            count    <= count + n_push - CNT_W'(pop);
            busy_vec <= busy_nxt;
            if (rr_toggle) begin
                rr_pri <= !rr_pri;
            end
        end
    end

    // Storage needs no reset; pushes are already suppressed during reset/flush
    always_ff @(posedge clk) begin
        if (first_push) begin
            mem[wr_ptr] <= first_entry;
        end
        if (second_push) begin
            mem[PTR_W'(wr_ptr + PTR_W'(1))] <= second_entry;
        end
    end

endmodule

// File: tb/tb_pred_wb_arbiter.sv
// Directed bench for pred_wb_arbiter: drain latency, dual push order, saturation
// fairness, scoreboard set/clear, flush and reset behaviour.
module tb_pred_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        alloc_valid;
    logic [3:0]  alloc_addr;
    logic        s0_valid;
    logic        s0_ready;
    logic [3:0]  s0_addr;
    logic        s0_data;
    logic        s1_valid;
    logic        s1_ready;
    logic [3:0]  s1_addr;
    logic        s1_data;
    logic        write_enable;
    logic [3:0]  write_addr;
    logic        data_in;
    logic [15:0] busy_vec;
    logic [3:0]  fifo_count;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    pred_wb_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .alloc_valid (alloc_valid),
        .alloc_addr  (alloc_addr),
        .s0_valid    (s0_valid),
        .s0_ready    (s0_ready),
        .s0_addr     (s0_addr),
        .s0_data     (s0_data),
        .s1_valid    (s1_valid),
        .s1_ready    (s1_ready),
        .s1_addr     (s1_addr),
        .s1_data     (s1_data),
        .write_enable(write_enable),
        .write_addr  (write_addr),
        .data_in     (data_in),
        .busy_vec    (busy_vec),
        .fifo_count  (fifo_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled after this
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        alloc_valid = 1'b0; alloc_addr = '0;
        s0_valid = 1'b0; s0_addr = '0; s0_data = 1'b0;
        s1_valid = 1'b0; s1_addr = '0; s1_data = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_busy", 32'(busy_vec), 0);
        chk("rst_we", 32'(write_enable), 0);
        chk("rst_ready0", 32'(s0_ready), 1);
        chk("rst_ready1", 32'(s1_ready), 1);

        // 1: allocate 3, then push 3 and see the write one cycle later
        alloc_valid = 1'b1; alloc_addr = 4'd3;
        tick();
        alloc_valid = 1'b0;
        chk("t1_busy_set", 32'(busy_vec), 32'h0008);
        s0_valid = 1'b1; s0_addr = 4'd3; s0_data = 1'b1;
        #1;
        chk("t1_ready0", 32'(s0_ready), 1);
        tick();
        s0_valid = 1'b0;
        #1;
        chk("t1_we", 32'(write_enable), 1);
        chk("t1_addr", 32'(write_addr), 3);
        chk("t1_data", 32'(data_in), 1);
        tick();
        chk("t1_busy_clr", 32'(busy_vec), 0);
        chk("t1_empty_we", 32'(write_enable), 0);

        // 2: dual push on empty FIFO, s0 ahead of s1
        s0_valid = 1'b1; s0_addr = 4'd1; s0_data = 1'b1;
        s1_valid = 1'b1; s1_addr = 4'd2; s1_data = 1'b0;
        #1;
        chk("t2_ready0", 32'(s0_ready), 1);
        chk("t2_ready1", 32'(s1_ready), 1);
        tick();
        s0_valid = 1'b0; s1_valid = 1'b0;
        #1;
        chk("t2_count", 32'(fifo_count), 2);
        chk("t2_w1_we", 32'(write_enable), 1);
        chk("t2_w1_addr", 32'(write_addr), 1);
        chk("t2_w1_data", 32'(data_in), 1);
        tick();
        chk("t2_w2_we", 32'(write_enable), 1);
        chk("t2_w2_addr", 32'(write_addr), 2);
        chk("t2_w2_data", 32'(data_in), 0);
        tick();
        chk("t2_drained", 32'(write_enable), 0);

        // 3: both sources streaming to addr 5 until saturation, then alternation
        s0_valid = 1'b1; s0_addr = 4'd5; s0_data = 1'b1;
        s1_valid = 1'b1; s1_addr = 4'd5; s1_data = 1'b0;
        #1;
        chk("t3_c0_r0", 32'(s0_ready), 1);
        chk("t3_c0_r1", 32'(s1_ready), 1);
        tick();
        chk("t3_c1_count", 32'(fifo_count), 2);
        chk("t3_c1_head", 32'(data_in), 1);
        chk("t3_c1_r1", 32'(s1_ready), 1);
        tick();
        chk("t3_c2_count", 32'(fifo_count), 3);
        chk("t3_c2_head", 32'(data_in), 0);
        chk("t3_c2_r0", 32'(s0_ready), 1);
        chk("t3_c2_r1", 32'(s1_ready), 1);
        tick();
        chk("t3_c3_count", 32'(fifo_count), 4);
        chk("t3_c3_r0", 32'(s0_ready), 1);
        chk("t3_c3_r1", 32'(s1_ready), 0);
        tick();
        chk("t3_c4_count", 32'(fifo_count), 4);
        chk("t3_c4_r0", 32'(s0_ready), 0);
        chk("t3_c4_r1", 32'(s1_ready), 1);
        tick();
        chk("t3_c5_r0", 32'(s0_ready), 1);
        chk("t3_c5_r1", 32'(s1_ready), 0);
        tick();
        s0_valid = 1'b0; s1_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("t3_drain_count", 32'(fifo_count), 0);
        chk("t3_drain_we", 32'(write_enable), 0);

        // 4: allocation and drain of the same predicate in one cycle
        s0_valid = 1'b1; s0_addr = 4'd7; s0_data = 1'b1;
        tick();
        s0_valid = 1'b0;
        alloc_valid = 1'b1; alloc_addr = 4'd7;
        #1;
        chk("t4_we", 32'(write_enable), 1);
        chk("t4_addr", 32'(write_addr), 7);
        tick();
        alloc_valid = 1'b0;
        chk("t4_busy_set_wins", 32'(busy_vec), 32'h0080);
        s0_valid = 1'b1;
        tick();
        s0_valid = 1'b0;
        tick();
        chk("t4_busy_clr", 32'(busy_vec), 0);

        // 5: three entries queued and 4..7 pending, then flush
        for (int i = 0; i < 4; i++) begin
            alloc_valid = 1'b1; alloc_addr = 4'(4 + i);
            tick();
        end
        alloc_valid = 1'b0;
        chk("t5_busy", 32'(busy_vec), 32'h00F0);
        s0_valid = 1'b1; s0_addr = 4'd0; s0_data = 1'b1;
        s1_valid = 1'b1; s1_addr = 4'd1; s1_data = 1'b1;
        tick();
        tick();
        s0_valid = 1'b0; s1_valid = 1'b0;
        chk("t5_count", 32'(fifo_count), 3);
        flush = 1'b1; alloc_valid = 1'b1; alloc_addr = 4'd9;
        s0_valid = 1'b1;
        #1;
        chk("t5_flush_we", 32'(write_enable), 0);
        chk("t5_flush_r0", 32'(s0_ready), 0);
        chk("t5_flush_r1", 32'(s1_ready), 0);
        tick();
        flush = 1'b0; alloc_valid = 1'b0; s0_valid = 1'b0;
        #1;
        chk("t5_post_count", 32'(fifo_count), 0);
        chk("t5_post_busy", 32'(busy_vec), 0);
        chk("t5_post_we", 32'(write_enable), 0);

        // 6: reset while entries are queued and s0 is offering
        s0_valid = 1'b1; s0_addr = 4'd10; s0_data = 1'b1;
        s1_valid = 1'b1; s1_addr = 4'd11; s1_data = 1'b1;
        tick();
        s1_valid = 1'b0;
        chk("t6_count", 32'(fifo_count), 2);
        reset = 1'b1;
        #1;
        chk("t6_rst_r0", 32'(s0_ready), 0);
        chk("t6_rst_r1", 32'(s1_ready), 0);
        chk("t6_rst_we", 32'(write_enable), 0);
        tick();
        reset = 1'b0; s0_valid = 1'b0;
        #1;
        chk("t6_post_count", 32'(fifo_count), 0);
        chk("t6_post_we", 32'(write_enable), 0);
        tick();
        chk("t6_no_stale_we", 32'(write_enable), 0);
        chk("t6_no_stale_count", 32'(fifo_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
